npu_output_stage: RTL and testbench

Parametrised next-generation NPU output path. It buffers fixed-point neuron outputs in an internal FIFO and converts each word to a 32-bit signed integer or an IEEE-754 single. Conversion uses a runtime-configurable binary scale, optional rounding and optional saturation. Results leave through a 2-stage pipeline with a valid/ready handshake toward the host-side bus.

---
 rtl/npu_out_pkg.sv | 27 ++
 rtl/npu_sync_fifo.sv | 62 ++++++
 rtl/npu_output_stage.sv | 159 +++++++++++++++
 tb/tb_npu_output_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_out_pkg.sv
// Shared definitions for the NPU output stage: config field layout, integer
// clamp limits, float bias and a leading-one detector.
package npu_out_pkg;

    localparam int CFG_MODE_BIT  = 15;
    localparam int CFG_SAT_BIT   = 14;
    localparam int CFG_RND_BIT   = 13;
    localparam int CFG_SCALE_MSB = 4;

    localparam logic MODE_INT   = 1'b0;
    localparam logic MODE_FLOAT = 1'b1;

    localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam int          FLT_BIAS = 127;

    // Index of the most significant set bit; 0 when the input is zero.
    function automatic logic [4:0] lod32(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// First-word-fall-through synchronous FIFO: dout shows the head word while not empty.
// Writes while full and reads while empty are ignored; count tracks occupancy.
module npu_sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW-1:0]            din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_acc, rd_acc;

    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign count  = cnt_q;
    assign dout   = mem_q[rd_ptr_q];
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/npu_output_stage.sv
// NPU output path: FIFO -> S1 (word + config snapshot) -> convert -> S2 (dout); push to dout in 2 edges.
// Both stages advance when dout is empty or accepted; a stalled dout holds data, flags and valid.
module npu_output_stage
    import npu_out_pkg::*;
#(
    parameter int DW    = 16,
    parameter int FRAC  = 7,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          npu_rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_wr_en,
    output logic          din_full,
    input  logic [15:0]   cfg_data,
    input  logic          cfg_wr_en,
    output logic [31:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          fifo_empty,
    output logic [CW-1:0] fifo_count,
    output logic          sat_flag,
    output logic          overflow_sticky,
    input  logic          clr_flags
);
    localparam int XW = DW + 33;

    logic [15:0]   cfg_q, cfg_d;
    logic          ovf_q, ovf_d;
    logic          s1_vld_q, s1_vld_d;
    logic [DW-1:0] s1_word_q, s1_word_d;
    logic [15:0]   s1_cfg_q, s1_cfg_d;
    logic [31:0]   dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          sat_q, sat_d;

    logic [DW-1:0] fifo_dout;
    logic          advance, pop;
    logic          cfg_rsvd_unused;

    npu_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (npu_rst_n),
        .din   (din),
        .wr_en (din_wr_en),
        .rd_en (pop),
        .dout  (fifo_dout),
        .full  (din_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign advance = !dout_vld_q || dout_ready;
    assign pop     = advance && !fifo_empty;

    // Reserved config bits are held in the register but never affect conversion.
    assign cfg_rsvd_unused = ^cfg_q[12:5];

    logic                 cv_mode, cv_sat_en, cv_rnd_en;
    logic [4:0]           cv_scale;
    int                   cv_sh;
    logic signed [XW-1:0] cv_x, cv_bias, cv_wide;
    logic                 cv_ovf;
    logic [DW:0]          cv_mag;
    logic [4:0]           cv_p;
    logic [7:0]           cv_exp;
    logic [22:0]          cv_man;
    logic [31:0]          cv_res;
    logic                 cv_sat;

    always_comb begin
        cv_mode   = s1_cfg_q[CFG_MODE_BIT];
        cv_sat_en = s1_cfg_q[CFG_SAT_BIT];
        cv_rnd_en = s1_cfg_q[CFG_RND_BIT];
        cv_scale  = s1_cfg_q[CFG_SCALE_MSB:0];
        cv_sh     = int'(cv_scale) - FRAC;
        cv_x      = XW'(signed'(s1_word_q));
        cv_bias   = '0;
        cv_wide   = '0;

        // Integer path: exact wide shift, optional round-half-up before the right shift.
        if (cv_sh >= 0) begin
            cv_wide = cv_x <<< cv_sh;
        end else begin
            if (cv_rnd_en) cv_bias = XW'(1) <<< (-cv_sh - 1);
            cv_wide = (cv_x + cv_bias) >>> (-cv_sh);
        end
        cv_ovf = (|cv_wide[XW-1:31]) && !(&cv_wide[XW-1:31]);

        // Float path: the magnitude always fits the 24-bit significand, so it is exact.
        cv_mag = s1_word_q[DW-1] ? (DW+1)'(-cv_x) : (DW+1)'(cv_x);
        cv_p   = lod32(32'(cv_mag));
        cv_exp = 8'(FLT_BIAS + int'(cv_p) - FRAC + int'(cv_scale));
        cv_man = 23'(32'(cv_mag) << (23 - int'(cv_p)));

        cv_sat = 1'b0;
        if (cv_mode == MODE_FLOAT) begin
            cv_res = (s1_word_q == '0) ? 32'h0 : {s1_word_q[DW-1], cv_exp, cv_man};
        end else if (cv_ovf && cv_sat_en) begin
            cv_res = cv_wide[XW-1] ? INT_MIN : INT_MAX;
            cv_sat = (cv_mode == MODE_INT);
        end else begin
            cv_res = cv_wide[31:0];
        end
    end

    always_comb begin
        cfg_d      = cfg_wr_en ? cfg_data : cfg_q;
        ovf_d      = ovf_q;
        s1_vld_d   = s1_vld_q;
        s1_word_d  = s1_word_q;
        s1_cfg_d   = s1_cfg_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        sat_d      = sat_q;

        // A dropped push outranks a simultaneous clear.
        if (clr_flags) ovf_d = 1'b0;
        if (din_wr_en && din_full) ovf_d = 1'b1;

        if (advance) begin
            s1_vld_d   = pop;
            s1_word_d  = fifo_dout;
            s1_cfg_d   = cfg_q;
            dout_vld_d = s1_vld_q;
            sat_d      = s1_vld_q && cv_sat;
            if (s1_vld_q) dout_d = cv_res;
        end
    end

    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            cfg_q      <= '0;
            ovf_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_word_q  <= '0;
            s1_cfg_q   <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            ovf_q      <= ovf_d;
            s1_vld_q   <= s1_vld_d;
            s1_word_q  <= s1_word_d;
            s1_cfg_q   <= s1_cfg_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            sat_q      <= sat_d;
        end
    end

    assign dout            = dout_q;
    assign dout_valid      = dout_vld_q;
    assign sat_flag        = sat_q;
    assign overflow_sticky = ovf_q;

endmodule

// File: tb/tb_npu_output_stage.sv
// Directed and randomized checks of npu_output_stage against an arithmetic reference model.
module tb_npu_output_stage;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          npu_rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_wr_en = 1'b0;
    logic          din_full;
    logic [15:0]   cfg_data = '0;
    logic          cfg_wr_en = 1'b0;
    logic [31:0]   dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          sat_flag;
    logic          overflow_sticky;
    logic          clr_flags = 1'b0;

    npu_output_stage #(.DW(DW), .FRAC(7), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK             (CLK),
        .npu_rst_n       (npu_rst_n),
        .din             (din),
        .din_wr_en       (din_wr_en),
        .din_full        (din_full),
        .cfg_data        (cfg_data),
        .cfg_wr_en       (cfg_wr_en),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .fifo_empty      (fifo_empty),
        .fifo_count      (fifo_count),
        .sat_flag        (sat_flag),
        .overflow_sticky (overflow_sticky),
        .clr_flags       (clr_flags)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];
    logic [32:0] rnd_q [$];

    logic [15:0] t_cfg [13] = '{16'h0000, 16'h0007, 16'h0000, 16'h0000, 16'h2000, 16'h2000,
                                16'h401F, 16'h401F, 16'h001F, 16'h8000, 16'h8000, 16'h8000, 16'h8007};
    logic [15:0] t_din [13] = '{16'h0180, 16'h0180, 16'h00C0, 16'hFF40, 16'h00C0, 16'hFF40,
                                16'h7FFF, 16'h8000, 16'h7FFF, 16'h0180, 16'hFF40, 16'h0000, 16'h0180};
    logic [31:0] t_exp [13] = '{32'h00000003, 32'h00000180, 32'h00000001, 32'hFFFFFFFE,
                                32'h00000002, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                                32'hFF000000, 32'h40400000, 32'hBFC00000, 32'h00000000,
                                32'h43C00000};
    logic        t_sat [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_cfg(input logic [15:0] v);
        cfg_data  = v;
        cfg_wr_en = 1'b1;
        step();
        cfg_wr_en = 1'b0;
    endtask

    // Value = din * 2^(scale-7), computed with plain integer/real arithmetic.
    function automatic void ref_conv(input logic [15:0] cfg, input logic [15:0] d,
                                     output logic [31:0] r, output logic s);
        int          sh, e;
        longint      v, x, den, num;
        real         rv;
        logic [63:0] b;
        sh = int'(cfg[4:0]) - 7;
        v  = longint'($signed(d));
        s  = 1'b0;
        r  = '0;
        if (cfg[15]) begin
            if (v != 0) begin
                rv = real'(v) * (2.0 ** sh);
                b  = $realtobits(rv);
                e  = int'(b[62:52]) - 1023 + 127;
                r  = {b[63], e[7:0], b[51:29]};
            end
        end else begin
            if (sh >= 0) begin
                x = v * (longint'(1) << sh);
            end else begin
                den = longint'(1) << (-sh);
                num = v + (cfg[13] ? den / 2 : 0);
                x   = num / den;
                if ((num % den != 0) && (num < 0)) x = x - 1;
            end
            if (cfg[14] && x > 64'sd2147483647) begin
                r = 32'h7FFFFFFF; s = 1'b1;
            end else if (cfg[14] && x < -64'sd2147483648) begin
                r = 32'h80000000; s = 1'b1;
            end else begin
                r = x[31:0];
            end
        end
    endfunction

    // Single push into an idle block with dout_ready=1: visible two edges after the push edge.
    task automatic run_one(input string tag, input bit do_cfg, input logic [15:0] cfg,
                           input logic [15:0] d, input logic [31:0] exp, input logic s);
        if (do_cfg) write_cfg(cfg);
        dout_ready = 1'b1;
        din        = d;
        din_wr_en  = 1'b1;
        step();
        din_wr_en  = 1'b0;
        chk({tag, "_vld_e1"}, 32'(dout_valid), 32'd0);
        step();
        chk({tag, "_vld_e2"}, 32'(dout_valid), 32'd0);
        step();
        chk({tag, "_vld_e3"}, 32'(dout_valid), 32'd1);
        chk({tag, "_dout"}, dout, exp);
        chk({tag, "_sat"}, 32'(sat_flag), 32'(s));
        step();
        chk({tag, "_vld_after"}, 32'(dout_valid), 32'd0);
    endtask

    // Words must appear back to back, one per cycle.
    task automatic drain_exp(input string tag);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            chk($sformatf("%s_vld%0d", tag, k), 32'(dout_valid), 32'd1);
            chk($sformatf("%s_dat%0d", tag, k), dout, exp_q.pop_front());
            k++;
            step();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        s;
        logic [15:0] cfg;
        logic [32:0] e;
        bit          wr;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_vld", 32'(dout_valid), 32'd0);
        chk("rst_sat", 32'(sat_flag), 32'd0);
        chk("rst_ovf", 32'(overflow_sticky), 32'd0);
        chk("rst_full", 32'(din_full), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        @(negedge CLK);
        npu_rst_n = 1'b1;
        step();

        // Directed conversion table
        for (int i = 0; i < 13; i++)
            run_one($sformatf("dir%0d", i), 1'b1, t_cfg[i], t_din[i], t_exp[i], t_sat[i]);

        // Config written while words are queued applies only to later pops
        write_cfg(16'h0000);
        dout_ready = 1'b0;
        din        = 16'h0180;
        din_wr_en  = 1'b1;
        repeat (3) step();
        din_wr_en  = 1'b0;
        write_cfg(16'h0007);
        dout_ready = 1'b1;
        exp_q = '{32'h3, 32'h3, 32'h180};
        drain_exp("cfgsnap");
        chk("cfgsnap_idle", 32'(dout_valid), 32'd0);

        // Backpressure and overflow
        dout_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            din       = 16'h0100 + 16'(i);
            din_wr_en = 1'b1;
            if (i < 18) exp_q.push_back(32'h100 + 32'(i));
            step();
        end
        din_wr_en = 1'b0;
        chk("bp_full", 32'(din_full), 32'd1);
        chk("bp_count", 32'(fifo_count), 32'd16);
        chk("bp_ovf", 32'(overflow_sticky), 32'd1);
        chk("bp_vld", 32'(dout_valid), 32'd1);
        chk("bp_dout", dout, 32'h100);
        repeat (3) step();
        chk("bp_hold_dout", dout, 32'h100);
        chk("bp_hold_vld", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        drain_exp("bp");
        chk("bp_idle", 32'(dout_valid), 32'd0);
        chk("bp_empty", 32'(fifo_empty), 32'd1);
        chk("bp_ovf_kept", 32'(overflow_sticky), 32'd1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("bp_ovf_clr", 32'(overflow_sticky), 32'd0);

        // Overflow with a simultaneous clear, then asynchronous reset mid-burst
        dout_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            din       = 16'h0200 + 16'(i);
            din_wr_en = 1'b1;
            clr_flags = (i >= 18);
            step();
        end
        din_wr_en = 1'b0;
        clr_flags = 1'b0;
        chk("clrset_ovf", 32'(overflow_sticky), 32'd1);
        dout_ready = 1'b1;
        step();
        #3;
        npu_rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(dout_valid), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_ovf", 32'(overflow_sticky), 32'd0);
        chk("arst_sat", 32'(sat_flag), 32'd0);
        chk("arst_empty", 32'(fifo_empty), 32'd1);
        chk("arst_full", 32'(din_full), 32'd0);
        chk("arst_dout", dout, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        npu_rst_n = 1'b1;
        step();
        run_one("post_rst", 1'b0, 16'h0000, 16'h0180, 32'h3, 1'b0);

        // Randomized bursts against the reference model
        for (int b = 0; b < 8; b++) begin
            cfg = 16'($urandom);
            write_cfg(cfg);
            for (int c = 0; c < 80; c++) begin
                dout_ready = 1'($urandom_range(0, 1));
                wr = ($urandom_range(0, 2) != 0) && (rnd_q.size() < DEPTH);
                case ($urandom_range(0, 7))
                    0:       din = 16'h8000;
                    1:       din = 16'h7FFF;
                    2:       din = 16'h0000;
                    default: din = 16'($urandom);
                endcase
                if (dout_valid && dout_ready) begin
                    if (rnd_q.size() == 0) begin
                        chk("rnd_extra", 32'(dout_valid), 32'd0);
                    end else begin
                        e = rnd_q.pop_front();
                        chk($sformatf("rnd_b%0d_dout", b), dout, e[31:0]);
                        chk($sformatf("rnd_b%0d_sat", b), 32'(sat_flag), 32'(e[32]));
                    end
                end
                if (wr) begin
                    chk("rnd_notfull", 32'(din_full), 32'd0);
                    ref_conv(cfg, din, r, s);
                    rnd_q.push_back({s, r});
                end
                din_wr_en = wr;
                step();
            end
            din_wr_en  = 1'b0;
            dout_ready = 1'b1;
            for (int c = 0; c < 60 && rnd_q.size() > 0; c++) begin
                if (dout_valid) begin
                    e = rnd_q.pop_front();
                    chk($sformatf("rnd_b%0d_ddout", b), dout, e[31:0]);
                    chk($sformatf("rnd_b%0d_dsat", b), 32'(sat_flag), 32'(e[32]));
                end
                step();
            end
            chk($sformatf("rnd_b%0d_left", b), 32'(rnd_q.size()), 32'd0);
            rnd_q.delete();
            repeat (2) step();
            chk($sformatf("rnd_b%0d_idle", b), 32'(dout_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
